rggen_bit_field_w01trg_ex: RTL and testbench

RGGEN_BIT_FIELD_W01TRG_EX -- requirements
Module: rggen_bit_field_w01trg_ex

---
 rtl/rggen_bit_field_w01trg_ex_if.sv | 16 +
 rtl/rggen_bit_field_w01trg_ex.sv | 87 ++++++++
 tb/tb_rggen_bit_field_w01trg_ex.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_bit_field_w01trg_ex_if.sv
// Register bit-field access bundle: write strobe/mask/data from the bus,
// readback and field value back to the register block.
interface rggen_bit_field_if #(
  parameter int unsigned WIDTH = 1
);
  logic             valid;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  valid, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_w01trg_ex.sv
// Write-0/1 trigger bit field with per-channel minimum pulse length and
// optional acknowledge handshake; read_data reports which channels are busy.
module rggen_bit_field_w01trg_ex #(
  parameter bit          TRIGGER_VALUE = 1'b0,
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned PULSE_CYCLES  = 1,
  parameter bit          ACK_MODE      = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  rggen_bit_field_if.bit_field    bit_field_if,
  input  logic [WIDTH-1:0]        i_ack,
  output logic [WIDTH-1:0]        o_trigger,
  output logic [WIDTH-1:0]        o_busy
);

  localparam int unsigned CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic             trigger_q;
    logic             busy_q;
    logic             req_c;
    logic             done_c;

    assign req_c  = bit_field_if.valid && bit_field_if.write_mask[i] &&
                    (bit_field_if.write_data[i] == TRIGGER_VALUE);
    assign done_c = ((state_q == PULSE) && (count_q == '0) && (!ACK_MODE || i_ack[i])) ||
                    ((state_q == WAIT_ACK) && i_ack[i]);

    // A request re-arms the channel only when idle or finishing this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q   <= IDLE;
        count_q   <= '0;
        trigger_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (req_c && ((state_q == IDLE) || done_c)) begin
        state_q   <= PULSE;
        count_q   <= CNT_LOAD;
        trigger_q <= 1'b1;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          PULSE: begin
            if (count_q != '0) begin
              count_q <= count_q - CNT_W'(1);
            end else if (done_c) begin
              state_q   <= IDLE;
              trigger_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              state_q <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (done_c) begin
              state_q   <= IDLE;
              trigger_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end

    assign o_trigger[i] = trigger_q;
    assign o_busy[i]    = busy_q;
  end

  assign bit_field_if.value     = o_trigger;
  assign bit_field_if.read_data = o_busy;

endmodule

// File: tb/tb_rggen_bit_field_w01trg_ex.sv
// Self-checking bench: directed scenarios on several parameterisations plus a
// randomized 8-channel run against a behavioural per-channel model.
module tb_rggen_bit_field_w01trg_ex;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rggen_bit_field_if #(.WIDTH(4)) if_a ();
  rggen_bit_field_if #(.WIDTH(2)) if_b ();
  rggen_bit_field_if #(.WIDTH(2)) if_c ();
  rggen_bit_field_if #(.WIDTH(1)) if_d ();
  rggen_bit_field_if #(.WIDTH(1)) if_e ();
  rggen_bit_field_if #(.WIDTH(8)) if_f ();
  rggen_bit_field_if #(.WIDTH(8)) if_g ();

  logic [3:0] ack_a, trig_a, busy_a;
  logic [1:0] ack_b, trig_b, busy_b;
  logic [1:0] ack_c, trig_c, busy_c;
  logic [0:0] ack_d, trig_d, busy_d;
  logic [0:0] ack_e, trig_e, busy_e;
  logic [7:0] ack_f, trig_f, busy_f;
  logic [7:0] ack_g, trig_g, busy_g;

  rggen_bit_field_w01trg_ex #(.TRIGGER_VALUE(1'b1), .WIDTH(4), .PULSE_CYCLES(1), .ACK_MODE(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_a.bit_field), .i_ack(ack_a), .o_trigger(trig_a), .o_busy(busy_a));
  rggen_bit_field_w01trg_ex #(.TRIGGER_VALUE(1'b0), .WIDTH(2), .PULSE_CYCLES(1), .ACK_MODE(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_b.bit_field), .i_ack(ack_b), .o_trigger(trig_b), .o_busy(busy_b));
  rggen_bit_field_w01trg_ex #(.TRIGGER_VALUE(1'b1), .WIDTH(2), .PULSE_CYCLES(4), .ACK_MODE(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_c.bit_field), .i_ack(ack_c), .o_trigger(trig_c), .o_busy(busy_c));
  rggen_bit_field_w01trg_ex #(.TRIGGER_VALUE(1'b1), .WIDTH(1), .PULSE_CYCLES(2), .ACK_MODE(1'b1)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_d.bit_field), .i_ack(ack_d), .o_trigger(trig_d), .o_busy(busy_d));
  rggen_bit_field_w01trg_ex #(.TRIGGER_VALUE(1'b1), .WIDTH(1), .PULSE_CYCLES(3), .ACK_MODE(1'b1)) u_e (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_e.bit_field), .i_ack(ack_e), .o_trigger(trig_e), .o_busy(busy_e));
  rggen_bit_field_w01trg_ex #(.TRIGGER_VALUE(1'b1), .WIDTH(8), .PULSE_CYCLES(3), .ACK_MODE(1'b1)) u_f (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_f.bit_field), .i_ack(ack_f), .o_trigger(trig_f), .o_busy(busy_f));
  rggen_bit_field_w01trg_ex #(.TRIGGER_VALUE(1'b0), .WIDTH(8), .PULSE_CYCLES(2), .ACK_MODE(1'b0)) u_g (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_g.bit_field), .i_ack(ack_g), .o_trigger(trig_g), .o_busy(busy_g));

  // Reference model state: active flag and minimum-pulse cycles still owed.
  bit act_m  [2][8];
  int left_m [2][8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_a.valid = 1'b0; if_a.write_mask = '0; if_a.write_data = '0; ack_a = '0;
    if_b.valid = 1'b0; if_b.write_mask = '0; if_b.write_data = '0; ack_b = '0;
    if_c.valid = 1'b0; if_c.write_mask = '0; if_c.write_data = '0; ack_c = '0;
    if_d.valid = 1'b0; if_d.write_mask = '0; if_d.write_data = '0; ack_d = '0;
    if_e.valid = 1'b0; if_e.write_mask = '0; if_e.write_data = '0; ack_e = '0;
    if_f.valid = 1'b0; if_f.write_mask = '0; if_f.write_data = '0; ack_f = '0;
    if_g.valid = 1'b0; if_g.write_mask = '0; if_g.write_data = '0; ack_g = '0;
  endtask

  function automatic void mdl(int s, bit tv, int pc, bit am, logic v,
                              logic [7:0] m, logic [7:0] d, logic [7:0] a);
    bit req;
    bit fin;
    for (int i = 0; i < 8; i++) begin
      req = v && m[i] && (d[i] == tv);
      fin = act_m[s][i] && (left_m[s][i] == 0) && (!am || a[i]);
      if (req && (!act_m[s][i] || fin)) begin
        act_m[s][i]  = 1'b1;
        left_m[s][i] = pc - 1;
      end else if (act_m[s][i]) begin
        if (left_m[s][i] > 0) left_m[s][i] = left_m[s][i] - 1;
        else if (fin)         act_m[s][i]  = 1'b0;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.valid = 1'b1; if_a.write_mask = '1; if_a.write_data = '1;
    if_f.valid = 1'b1; if_f.write_mask = '1; if_f.write_data = '1;
    if_g.valid = 1'b1; if_g.write_mask = '1; if_g.write_data = '0;
    repeat (3) step();
    total++;
    if ({trig_a, busy_a, if_a.value, if_a.read_data} !== 16'h0) begin
      bad++; $display("FAIL reset_a got=%h exp=0", {trig_a, busy_a, if_a.value, if_a.read_data});
    end
    total++;
    if ({trig_f, busy_f, if_f.value, if_f.read_data} !== 32'h0) begin
      bad++; $display("FAIL reset_f got=%h exp=0", {trig_f, busy_f, if_f.value, if_f.read_data});
    end
    total++;
    if ({trig_g, busy_g, trig_c, busy_c, trig_d, busy_d, trig_e, busy_e} !== 24'h0) begin
      bad++; $display("FAIL reset_other got=%h exp=0", {trig_g, busy_g, trig_c, busy_c, trig_d, busy_d, trig_e, busy_e});
    end
    idle_all();
    rst_n = 1'b1;
    if_a.valid = 1'b1; if_a.write_mask = 4'h1; if_a.write_data = 4'h1;
    step();
    total++;
    if (trig_a !== 4'h1) begin
      bad++; $display("FAIL first_after_reset got=%h exp=1", trig_a);
    end
    idle_all();
    step();
  endtask

  task automatic test_w1trg();
    if_a.valid = 1'b1; if_a.write_mask = 4'hF; if_a.write_data = 4'h5;
    step();
    total++;
    if ({trig_a, if_a.value, if_a.read_data, busy_a} !== 16'h5555) begin
      bad++; $display("FAIL w1trg_fire got=%h exp=5555", {trig_a, if_a.value, if_a.read_data, busy_a});
    end
    idle_all();
    step();
    total++;
    if ({trig_a, busy_a} !== 8'h00) begin
      bad++; $display("FAIL w1trg_clear got=%h exp=00", {trig_a, busy_a});
    end
    if_a.valid = 1'b1; if_a.write_mask = 4'h0; if_a.write_data = 4'hF;
    step();
    total++;
    if (trig_a !== 4'h0) begin
      bad++; $display("FAIL w1trg_masked got=%h exp=0", trig_a);
    end
    if_a.write_mask = 4'hF; if_a.write_data = 4'h0;
    step();
    total++;
    if (trig_a !== 4'h0) begin
      bad++; $display("FAIL w1trg_wrong_value got=%h exp=0", trig_a);
    end
    idle_all();
    step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      if_a.valid = 1'b1; if_a.write_mask = 4'h9; if_a.write_data = 4'h9;
      step();
      total++;
      if (trig_a !== 4'h9) begin
        bad++; $display("FAIL back_to_back k=%0d got=%h exp=9", k, trig_a);
      end
    end
    idle_all();
    step();
    total++;
    if (trig_a !== 4'h0) begin
      bad++; $display("FAIL back_to_back_end got=%h exp=0", trig_a);
    end
  endtask

  task automatic test_w0trg();
    if_b.valid = 1'b1; if_b.write_mask = 2'h3; if_b.write_data = 2'h1;
    step();
    total++;
    if ({trig_b, if_b.read_data} !== 4'hA) begin
      bad++; $display("FAIL w0trg_fire got=%h exp=a", {trig_b, if_b.read_data});
    end
    if_b.write_mask = 2'h0; if_b.write_data = 2'h0;
    step();
    total++;
    if (trig_b !== 2'h0) begin
      bad++; $display("FAIL w0trg_masked got=%h exp=0", trig_b);
    end
    idle_all();
    step();
  endtask

  task automatic test_min_pulse();
    logic exp;
    for (int k = 0; k < 10; k++) begin
      idle_all();
      if (k == 0 || k == 2 || k == 4) begin
        if_c.valid = 1'b1; if_c.write_mask = 2'h1; if_c.write_data = 2'h1;
      end
      step();
      exp = (k <= 7);
      total++;
      if (trig_c !== {1'b0, exp} || busy_c !== {1'b0, exp}) begin
        bad++; $display("FAIL min_pulse cycle=n+%0d got=%h/%h exp=%h", k + 1, trig_c, busy_c, {1'b0, exp});
      end
    end
    idle_all();
  endtask

  task automatic test_ack();
    logic exp;
    for (int k = 0; k < 8; k++) begin
      idle_all();
      if (k == 0) begin
        if_d.valid = 1'b1; if_d.write_mask = 1'b1; if_d.write_data = 1'b1;
      end
      if (k == 1 || k == 5) ack_d = 1'b1;
      step();
      exp = (k <= 4);
      total++;
      if (trig_d !== exp || busy_d !== exp || if_d.read_data !== exp) begin
        bad++; $display("FAIL ack_hold cycle=n+%0d got=%b%b exp=%b", k + 1, trig_d, busy_d, exp);
      end
    end
    idle_all();
  endtask

  task automatic test_reset_abort();
    if_e.valid = 1'b1; if_e.write_mask = 1'b1; if_e.write_data = 1'b1;
    step();
    idle_all();
    repeat (3) step();
    total++;
    if (trig_e !== 1'b1) begin
      bad++; $display("FAIL abort_pre got=%b exp=1", trig_e);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({trig_e, busy_e, if_e.value, if_e.read_data} !== 4'h0) begin
      bad++; $display("FAIL abort_async got=%h exp=0", {trig_e, busy_e, if_e.value, if_e.read_data});
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    total++;
    if ({trig_e, busy_e} !== 2'b00) begin
      bad++; $display("FAIL abort_no_resume got=%b exp=00", {trig_e, busy_e});
    end
    if_e.valid = 1'b1; if_e.write_mask = 1'b1; if_e.write_data = 1'b1;
    step();
    idle_all();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (trig_e !== 1'b1) begin
        bad++; $display("FAIL abort_new_pulse k=%0d got=%b exp=1", k, trig_e);
      end
      step();
    end
    ack_e = 1'b1;
    step();
    idle_all();
    total++;
    if ({trig_e, busy_e} !== 2'b00) begin
      bad++; $display("FAIL abort_ack_release got=%b exp=00", {trig_e, busy_e});
    end
  endtask

  task automatic test_random();
    logic       v_f, v_g;
    logic [7:0] m_f, d_f, a_f, m_g, d_g, a_g, exp_f, exp_g;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) begin
        act_m[s][i] = 1'b0; left_m[s][i] = 0;
      end
    for (int n = 0; n < 400; n++) begin
      v_f = 1'($urandom_range(0, 1)); m_f = 8'($urandom); d_f = 8'($urandom); a_f = 8'($urandom);
      v_g = 1'($urandom_range(0, 1)); m_g = 8'($urandom); d_g = 8'($urandom); a_g = 8'($urandom);
      if_f.valid = v_f; if_f.write_mask = m_f; if_f.write_data = d_f; ack_f = a_f;
      if_g.valid = v_g; if_g.write_mask = m_g; if_g.write_data = d_g; ack_g = a_g;
      mdl(0, 1'b1, 3, 1'b1, v_f, m_f, d_f, a_f);
      mdl(1, 1'b0, 2, 1'b0, v_g, m_g, d_g, a_g);
      step();
      for (int i = 0; i < 8; i++) begin
        exp_f[i] = act_m[0][i];
        exp_g[i] = act_m[1][i];
      end
      total++;
      if (trig_f !== exp_f || busy_f !== exp_f || if_f.read_data !== exp_f || if_f.value !== exp_f) begin
        bad++; $display("FAIL random_f cycle=%0d got=%h/%h/%h exp=%h", n, trig_f, busy_f, if_f.read_data, exp_f);
      end
      total++;
      if (trig_g !== exp_g || busy_g !== exp_g || if_g.read_data !== exp_g || if_g.value !== exp_g) begin
        bad++; $display("FAIL random_g cycle=%0d got=%h/%h/%h exp=%h", n, trig_g, busy_g, if_g.read_data, exp_g);
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_w1trg();
    test_back_to_back();
    test_w0trg();
    test_min_pulse();
    test_ack();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
